ram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one RAM_SINGLE_READ_PORT instance (1-cycle synchronous read, write on Clock edge) between two clients, e.g. the control FSM and a display/scan engine.
- Grants at most one access (read or write) per cycle, round-robin, with a registered request-to-RAM path.
- Returns read data tagged to the owner with a fixed latency.
- Sits between the clients and the RAM ports.

---
 rtl/ram_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-read-port RAM (1-cycle synchronous read).
// Grants at most one access per cycle. Requesters are served round-robin, and a
// requester is never granted on two consecutive edges. Grant, address, write data
// and write enable are all registered toward the RAM. Read data returns on
// oRdData two edges after the grant edge, tagged by oRdValid0/oRdValid1.
// Build option: define RAM_ARB_FIXED_PRIORITY_EN so that requester 0 always wins
// a tie; the round-robin pointer is then removed.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReq0,
  input  logic                  iWe0,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [DATA_WIDTH-1:0] iData0,
  output logic                  oGnt0,
  output logic                  oRdValid0,
  input  logic                  iReq1,
  input  logic                  iWe1,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oGnt1,
  output logic                  oRdValid1,
  output logic [DATA_WIDTH-1:0] oRdData,
  output logic                  oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress,
  output logic [DATA_WIDTH-1:0] oRamDataIn,
  input  logic [DATA_WIDTH-1:0] iRamDataOut
);

  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_own_q, s1_own_d;
  logic                  s2_vld_q, s2_own_q;
  logic                  rdv0_q, rdv1_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  elig0, elig1;
  logic                  sel0, sel1;

  // Eligibility: a requester that was granted in the previous cycle sits out this edge.
  always_comb begin
    elig0 = iReq0 & ~gnt0_q;
    elig1 = iReq1 & ~gnt1_q;
  end

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: requester 0 wins any tie.
  always_comb begin
    sel0 = elig0;
    sel1 = elig1 & ~elig0;
  end
`else
  logic ptr_q, ptr_d;  // 0: requester 0 wins the next tie, 1: requester 1 wins it

  // Round-robin choice; the pointer moves only when both requesters were eligible.
  always_comb begin
    sel0  = elig0 & (~elig1 | ~ptr_q);
    sel1  = elig1 & ~sel0;
    ptr_d = ptr_q;
    if (elig0 && elig1) ptr_d = sel0;
  end

  // Tie-break pointer register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`endif

  // Next RAM command. With no grant, the address and data hold their values and the write enable drops.
  always_comb begin
    gnt0_d   = sel0;
    gnt1_d   = sel1;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    s1_vld_d = 1'b0;
    s1_own_d = 1'b0;
    if (sel0) begin
      we_d     = iWe0;
      addr_d   = iAddr0;
      wdata_d  = iData0;
      s1_vld_d = ~iWe0;
    end else if (sel1) begin
      we_d     = iWe1;
      addr_d   = iAddr1;
      wdata_d  = iData1;
      s1_vld_d = ~iWe1;
      s1_own_d = 1'b1;
    end
  end

  // Grant and RAM command registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read return pipeline: grant edge -> RAM capture edge -> oRdData capture edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_vld_q <= 1'b0;
      s1_own_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_own_q <= 1'b0;
      rdv0_q   <= 1'b0;
      rdv1_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_own_q <= s1_own_d;
      s2_vld_q <= s1_vld_q;
      s2_own_q <= s1_own_q;
      rdv0_q   <= s2_vld_q & ~s2_own_q;
      rdv1_q   <= s2_vld_q & s2_own_q;
      if (s2_vld_q) rdata_q <= iRamDataOut;
    end
  end

  assign oGnt0            = gnt0_q;
  assign oGnt1            = gnt1_q;
  assign oRdValid0        = rdv0_q;
  assign oRdValid1        = rdv1_q;
  assign oRdData          = rdata_q;
  assign oRamWriteEnable  = we_q;
  assign oRamWriteAddress = addr_q;
  assign oRamReadAddress  = addr_q;
  assign oRamDataIn       = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter, with a behavioural single-read-port RAM attached.
module tb_ram_port_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iReq0 = 1'b0, iWe0 = 1'b0, iReq1 = 1'b0, iWe1 = 1'b0;
  logic [7:0]  iAddr0 = '0, iAddr1 = '0;
  logic [15:0] iData0 = '0, iData1 = '0;
  logic        oGnt0, oGnt1, oRdValid0, oRdValid1;
  logic [15:0] oRdData, oRamDataIn;
  logic        oRamWriteEnable;
  logic [7:0]  oRamWriteAddress, oRamReadAddress;
  logic [15:0] ram_dout;
  logic [15:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .iReq0(iReq0), .iWe0(iWe0), .iAddr0(iAddr0), .iData0(iData0),
    .oGnt0(oGnt0), .oRdValid0(oRdValid0),
    .iReq1(iReq1), .iWe1(iWe1), .iAddr1(iAddr1), .iData1(iData1),
    .oGnt1(oGnt1), .oRdValid1(oRdValid1),
    .oRdData(oRdData),
    .oRamWriteEnable(oRamWriteEnable),
    .oRamWriteAddress(oRamWriteAddress),
    .oRamReadAddress(oRamReadAddress),
    .oRamDataIn(oRamDataIn),
    .iRamDataOut(ram_dout)
  );

  always #5 Clock = ~Clock;

  // Behavioural RAM: write on the edge, registered read of the pre-edge contents.
  always @(posedge Clock) begin
    if (oRamWriteEnable) mem[oRamWriteAddress] <= oRamDataIn;
    ram_dout <= mem[oRamReadAddress];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt0"}, oGnt0, 0);
    chk({tag, " gnt1"}, oGnt1, 0);
    chk({tag, " rdv0"}, oRdValid0, 0);
    chk({tag, " rdv1"}, oRdValid1, 0);
    chk({tag, " rdata"}, oRdData, 0);
    chk({tag, " we"}, oRamWriteEnable, 0);
    chk({tag, " waddr"}, oRamWriteAddress, 0);
    chk({tag, " raddr"}, oRamReadAddress, 0);
    chk({tag, " din"}, oRamDataIn, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h05] = 16'h1234;

    // Reset state
    #12;
    chk_all_zero("rst");
    @(negedge Clock);
    Reset = 1'b0;

    // Single read by requester 0 of 0x05
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 8'h05;
    tick();
    chk("t1 gnt0", oGnt0, 1);
    chk("t1 gnt1", oGnt1, 0);
    chk("t1 raddr", oRamReadAddress, 8'h05);
    chk("t1 we", oRamWriteEnable, 0);
    iReq0 = 1'b0;
    tick();
    chk("t1 e2 gnt0", oGnt0, 0);
    chk("t1 e2 rdv0", oRdValid0, 0);
    tick();
    chk("t1 e3 rdv0", oRdValid0, 1);
    chk("t1 e3 rdata", oRdData, 16'h1234);
    chk("t1 e3 rdv1", oRdValid1, 0);
    tick();
    chk("t1 e4 rdv0", oRdValid0, 0);

    // Requester 1 writes 0xBEEF to 0x10, then requester 0 reads 0x10
    iReq1 = 1'b1; iWe1 = 1'b1; iAddr1 = 8'h10; iData1 = 16'hBEEF;
    tick();
    chk("t2 gnt1", oGnt1, 1);
    chk("t2 we", oRamWriteEnable, 1);
    chk("t2 waddr", oRamWriteAddress, 8'h10);
    chk("t2 din", oRamDataIn, 16'hBEEF);
    iReq1 = 1'b0; iWe1 = 1'b0;
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 8'h10;
    tick();
    chk("t2 e2 gnt0", oGnt0, 1);
    chk("t2 e2 we", oRamWriteEnable, 0);
    chk("t2 e2 raddr", oRamReadAddress, 8'h10);
    iReq0 = 1'b0;
    tick();
    chk("t2 e3 rdv0", oRdValid0, 0);
    tick();
    chk("t2 e4 rdv0", oRdValid0, 1);
    chk("t2 e4 rdata", oRdData, 16'hBEEF);
    chk("t2 e4 rdv1", oRdValid1, 0);

    // Both requesters read continuously from reset: strict alternation 0,1,0,...
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("t3 rst gnt0", oGnt0, 0);
    @(negedge Clock);
    Reset = 1'b0;
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 8'h05;
    iReq1 = 1'b1; iWe1 = 1'b0; iAddr1 = 8'h10;
    for (int k = 1; k <= 8; k++) begin
      logic eg0, eg1, ev0, ev1;
      tick();
      eg0 = (k <= 6) && (k % 2 == 1);
      eg1 = (k <= 6) && (k % 2 == 0);
      ev0 = (k >= 3) && ((k - 2) % 2 == 1);
      ev1 = (k >= 3) && ((k - 2) % 2 == 0);
      chk($sformatf("t3 e%0d gnt0", k), oGnt0, eg0);
      chk($sformatf("t3 e%0d gnt1", k), oGnt1, eg1);
      chk($sformatf("t3 e%0d rdv0", k), oRdValid0, ev0);
      chk($sformatf("t3 e%0d rdv1", k), oRdValid1, ev1);
      if (ev0) chk($sformatf("t3 e%0d rdata", k), oRdData, 16'h1234);
      if (ev1) chk($sformatf("t3 e%0d rdata", k), oRdData, 16'hBEEF);
      if (k == 6) begin
        iReq0 = 1'b0;
        iReq1 = 1'b0;
      end
    end

    // Requester 0 alone held for 6 edges: granted on alternate edges
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 8'h05;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("t4 e%0d gnt0", k), oGnt0, (k % 2 == 1));
      chk($sformatf("t4 e%0d we", k), oRamWriteEnable, 0);
    end
    iReq0 = 1'b0;
    tick();
    tick();
    tick();

    // Asynchronous reset between a grant and its read return
    iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 8'h05;
    tick();
    chk("t5 gnt0", oGnt0, 1);
    #3;
    Reset = 1'b1;
    iReq1 = 1'b1; iWe1 = 1'b0; iAddr1 = 8'h10;
    #1;
    chk_all_zero("t5 async");
    tick();
    chk("t5 held rdv0", oRdValid0, 0);
    tick();
    chk("t5 held2 rdv0", oRdValid0, 0);
    @(negedge Clock);
    Reset = 1'b0;
    tick();
    chk("t5 r1 gnt0", oGnt0, 1);
    chk("t5 r1 gnt1", oGnt1, 0);
    chk("t5 r1 rdv0", oRdValid0, 0);
    tick();
    chk("t5 r2 gnt1", oGnt1, 1);
    chk("t5 r2 rdv0", oRdValid0, 0);
    chk("t5 r2 rdv1", oRdValid1, 0);
    iReq0 = 1'b0;
    iReq1 = 1'b0;
    tick();
    chk("t5 r3 rdv0", oRdValid0, 1);
    chk("t5 r3 rdata", oRdData, 16'h1234);
    tick();
    chk("t5 r4 rdv1", oRdValid1, 1);
    chk("t5 r4 rdv0", oRdValid0, 0);
    chk("t5 r4 rdata", oRdData, 16'hBEEF);

    // Write to 0x22, then 5 idle cycles: addresses hold, nothing else happens
    iReq0 = 1'b1; iWe0 = 1'b1; iAddr0 = 8'h22; iData0 = 16'h5A5A;
    tick();
    chk("t6 gnt0", oGnt0, 1);
    chk("t6 we", oRamWriteEnable, 1);
    chk("t6 waddr", oRamWriteAddress, 8'h22);
    chk("t6 din", oRamDataIn, 16'h5A5A);
    iReq0 = 1'b0; iWe0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("t6 i%0d we", k), oRamWriteEnable, 0);
      chk($sformatf("t6 i%0d waddr", k), oRamWriteAddress, 8'h22);
      chk($sformatf("t6 i%0d raddr", k), oRamReadAddress, 8'h22);
      chk($sformatf("t6 i%0d gnt", k), {oGnt0, oGnt1}, 0);
      chk($sformatf("t6 i%0d rdv", k), {oRdValid0, oRdValid1}, 0);
    end
    chk("t6 mem22", mem[8'h22], 16'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
